// File: rtl/fp32_mul_pack.sv
// rtl/fp32_mul_pack.sv - fp32 multiplier back end: normalize, round-to-nearest-even, pack
// Optional status flags output enabled by defining FP_PACK_FLAGS_EN.
module fp32_mul_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [63:0] in_prod,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [1:0]  in_spec,
  output logic        out_val,
  input  logic        out_rdy,
`ifdef FP_PACK_FLAGS_EN
  output logic [2:0]  out_flags,
`endif
  output logic [31:0] out_msg
);

  localparam logic [1:0] SPEC_NORM = 2'b00;
  localparam logic [1:0] SPEC_ZERO = 2'b01;
  localparam logic [1:0] SPEC_INF  = 2'b10;

  // Upper product bits carry no information for a 24x24 multiply.
  logic unused_prod_hi;
  assign unused_prod_hi = ^in_prod[63:48];

  // Both stages move together; a stalled output freezes the whole pipe.
  logic adv;
  assign adv    = !out_val || out_rdy;
  assign in_rdy = adv;

  // Stage 1 state
  logic        s1_val_q;
  logic [22:0] s1_m_q,    s1_m_d;
  logic        s1_g_q,    s1_g_d;
  logic        s1_s_q,    s1_s_d;
  logic [9:0]  s1_e_q,    s1_e_d;
  logic        s1_sign_q;
  logic [1:0]  s1_spec_q;
`ifdef FP_PACK_FLAGS_EN
  logic        s1_nz_q;
`endif

  // Stage 2 state
  logic        out_val_q;
  logic [31:0] out_msg_q, out_msg_d;
`ifdef FP_PACK_FLAGS_EN
  logic [2:0]  out_flags_q, out_flags_d;
`endif

  // Normalize: a product in [2,4) has its leading one at bit 47, else at bit 46.
  always_comb begin
    s1_m_d = 23'd0;
    s1_g_d = 1'b0;
    s1_s_d = 1'b0;
    s1_e_d = in_exp;
    if (in_prod[47]) begin
      s1_m_d = in_prod[46:24];
      s1_g_d = in_prod[23];
      s1_s_d = |in_prod[22:0];
      s1_e_d = in_exp + 10'd1;
    end else begin
      s1_m_d = in_prod[45:23];
      s1_g_d = in_prod[22];
      s1_s_d = |in_prod[21:0];
    end
  end

  // Stage 1 register: captures a normalized product whenever the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_val_q  <= 1'b0;
      s1_m_q    <= 23'd0;
      s1_g_q    <= 1'b0;
      s1_s_q    <= 1'b0;
      s1_e_q    <= 10'd0;
      s1_sign_q <= 1'b0;
      s1_spec_q <= 2'b00;
`ifdef FP_PACK_FLAGS_EN
      s1_nz_q   <= 1'b0;
`endif
    end else if (adv) begin
      s1_val_q <= in_val;
      if (in_val) begin
        s1_m_q    <= s1_m_d;
        s1_g_q    <= s1_g_d;
        s1_s_q    <= s1_s_d;
        s1_e_q    <= s1_e_d;
        s1_sign_q <= in_sign;
        s1_spec_q <= in_spec;
`ifdef FP_PACK_FLAGS_EN
        s1_nz_q   <= |in_prod[47:0];
`endif
      end
    end
  end

  // Round-to-nearest-even; the exponent is widened so a rounding carry cannot wrap it.
  logic        rnd_up;
  logic [23:0] m_sum;
  logic [10:0] e_rnd;
  logic        ovf, unf;
  assign rnd_up = s1_g_q && (s1_s_q || s1_m_q[0]);
  assign m_sum  = {1'b0, s1_m_q} + {23'd0, rnd_up};
  assign e_rnd  = {s1_e_q[9], s1_e_q} + {10'd0, m_sum[23]};
  assign ovf    = $signed(e_rnd) >= 11'sd255;
  assign unf    = $signed(s1_e_q) <= 10'sd0;

  // Pack: specials override arithmetic, underflow is judged before rounding.
  always_comb begin
    out_msg_d = {s1_sign_q, s1_e_q[7:0], m_sum[22:0]};
`ifdef FP_PACK_FLAGS_EN
    out_flags_d = {2'b00, s1_g_q || s1_s_q};
`endif
    if (s1_spec_q == SPEC_NORM) begin
      if (unf) begin
        out_msg_d = {s1_sign_q, 31'd0};
`ifdef FP_PACK_FLAGS_EN
        out_flags_d = {1'b0, 1'b1, s1_nz_q};
`endif
      end else if (ovf) begin
        out_msg_d = {s1_sign_q, 8'hFF, 23'd0};
`ifdef FP_PACK_FLAGS_EN
        out_flags_d = 3'b101;
`endif
      end else begin
        out_msg_d = {s1_sign_q, e_rnd[7:0], m_sum[22:0]};
      end
    end else begin
`ifdef FP_PACK_FLAGS_EN
      out_flags_d = 3'b000;
`endif
      if (s1_spec_q == SPEC_ZERO) begin
        out_msg_d = {s1_sign_q, 31'd0};
      end else if (s1_spec_q == SPEC_INF) begin
        out_msg_d = {s1_sign_q, 8'hFF, 23'd0};
      end else begin
        out_msg_d = 32'h7FC0_0000;
      end
    end
  end

  // Stage 2 register: result is held unchanged while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val_q <= 1'b0;
      out_msg_q <= 32'd0;
`ifdef FP_PACK_FLAGS_EN
      out_flags_q <= 3'b000;
`endif
    end else if (adv) begin
      out_val_q <= s1_val_q;
      if (s1_val_q) begin
        out_msg_q <= out_msg_d;
`ifdef FP_PACK_FLAGS_EN
        out_flags_q <= out_flags_d;
`endif
      end
    end
  end

  assign out_val = out_val_q;
  assign out_msg = out_msg_q;
`ifdef FP_PACK_FLAGS_EN
  assign out_flags = out_flags_q;
`endif

endmodule

// File: tb/tb_fp32_mul_pack.sv
// tb/tb_fp32_mul_pack.sv - directed table-driven bench for fp32_mul_pack
module tb_fp32_mul_pack;

  logic        clk;
  logic        rst_n;
  logic        in_val;
  logic        in_rdy;
  logic [63:0] in_prod;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [1:0]  in_spec;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_msg;
`ifdef FP_PACK_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  fp32_mul_pack dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_prod  (in_prod),
    .in_sign  (in_sign),
    .in_exp   (in_exp),
    .in_spec  (in_spec),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
`ifdef FP_PACK_FLAGS_EN
    .out_flags(out_flags),
`endif
    .out_msg  (out_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    logic        sign;
    logic [9:0]  exp;
    logic [1:0]  spec;
    logic [31:0] msg;
    logic [2:0]  flg;
  } vec_t;

  typedef struct {
    logic [31:0] msg;
    logic [2:0]  flg;
  } res_t;

  localparam int NV = 19;
  vec_t tbl [NV];
  res_t got [$];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [63:0] p, input logic s, input logic [9:0] e,
                              input logic [1:0] c, input logic [31:0] m, input logic [2:0] f);
    vec_t v;
    v.prod = p; v.sign = s; v.exp = e; v.spec = c; v.msg = m; v.flg = f;
    return v;
  endfunction

  // Output monitor: records accepted results and checks hold-stability during stalls.
  logic        stall_prev = 1'b0;
  logic [31:0] hold_msg   = 32'd0;
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (stall_prev) chk("hold_stable", out_msg, hold_msg);
      if (out_val && out_rdy) begin
        res_t r;
        r.msg = out_msg;
`ifdef FP_PACK_FLAGS_EN
        r.flg = out_flags;
`else
        r.flg = 3'b000;
`endif
        got.push_back(r);
      end
      stall_prev = out_val && !out_rdy;
      hold_msg   = out_msg;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input vec_t v);
    int n;
    @(negedge clk);
    in_val  = 1'b1;
    in_prod = v.prod;
    in_sign = v.sign;
    in_exp  = v.exp;
    in_spec = v.spec;
    #1;
    n = 0;
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_val = 1'b0;
  endtask

  task automatic wait_results(input int want);
    int n;
    n = 0;
    while (got.size() < want && n < 40) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("result_count", got.size(), want);
  endtask

  initial begin
    tbl[0]  = mk(64'h0000_4000_0000_0000, 1'b0, 10'd127,  2'b00, 32'h3F80_0000, 3'b000);
    tbl[1]  = mk(64'h0000_9000_0000_0000, 1'b0, 10'd127,  2'b00, 32'h4010_0000, 3'b000);
    tbl[2]  = mk(64'h0000_9000_0000_0000, 1'b1, 10'd127,  2'b00, 32'hC010_0000, 3'b000);
    tbl[3]  = mk(64'h0000_8000_0180_0000, 1'b0, 10'd127,  2'b00, 32'h4000_0002, 3'b001);
    tbl[4]  = mk(64'h0000_8000_0080_0000, 1'b0, 10'd127,  2'b00, 32'h4000_0000, 3'b001);
    tbl[5]  = mk(64'h0000_9000_0000_0000, 1'b0, 10'd254,  2'b00, 32'h7F80_0000, 3'b101);
    tbl[6]  = mk(64'h0000_4000_0000_0000, 1'b1, 10'h37E,  2'b00, 32'h8000_0000, 3'b011);
    tbl[7]  = mk(64'h0000_4000_0000_0000, 1'b1, 10'd127,  2'b11, 32'h7FC0_0000, 3'b000);
    tbl[8]  = mk(64'h0000_4000_0000_0000, 1'b1, 10'd127,  2'b10, 32'hFF80_0000, 3'b000);
    tbl[9]  = mk(64'h0000_9000_0000_0000, 1'b0, 10'd127,  2'b01, 32'h0000_0000, 3'b000);
    tbl[10] = mk(64'h0000_7FFF_FFC0_0000, 1'b0, 10'd127,  2'b00, 32'h4000_0000, 3'b001);
    tbl[11] = mk(64'h0000_7FFF_FFC0_0000, 1'b0, 10'd254,  2'b00, 32'h7F80_0000, 3'b101);
    tbl[12] = mk(64'h0000_8000_0000_0000, 1'b0, 10'd0,    2'b00, 32'h0080_0000, 3'b000);
    tbl[13] = mk(64'h0000_4000_0000_0000, 1'b0, 10'd0,    2'b00, 32'h0000_0000, 3'b011);
    tbl[14] = mk(64'hFFFF_4000_0000_0000, 1'b0, 10'd127,  2'b00, 32'h3F80_0000, 3'b000);
    tbl[15] = mk(64'h0000_0000_0000_0000, 1'b0, 10'd0,    2'b00, 32'h0000_0000, 3'b010);
    tbl[16] = mk(64'h0000_4000_0040_0001, 1'b0, 10'd127,  2'b00, 32'h3F80_0001, 3'b001);
    tbl[17] = mk(64'h0000_4000_0000_0001, 1'b0, 10'd127,  2'b00, 32'h3F80_0000, 3'b001);
    tbl[18] = mk(64'h0000_9000_0000_0000, 1'b0, 10'd253,  2'b00, 32'h7F10_0000, 3'b000);

    rst_n = 1'b0; in_val = 1'b0; in_prod = 64'd0; in_sign = 1'b0;
    in_exp = 10'd0; in_spec = 2'b00; out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_val", {31'd0, out_val}, 32'd0);
    chk("reset_out_msg", out_msg, 32'd0);
`ifdef FP_PACK_FLAGS_EN
    chk("reset_out_flags", {29'd0, out_flags}, 32'd0);
`endif
    chk("reset_in_rdy", {31'd0, in_rdy}, 32'd1);
    rst_n = 1'b1;

    // Latency: accepted at P0, visible after P1.
    send(tbl[0]);
    @(negedge clk); #1;
    chk("lat_cycle1_val", {31'd0, out_val}, 32'd0);
    @(negedge clk); #1;
    chk("lat_cycle2_val", {31'd0, out_val}, 32'd1);
    chk("lat_cycle2_msg", out_msg, tbl[0].msg);
    repeat (2) @(negedge clk);
    got.delete();

    // Full table streamed back-to-back.
    for (int i = 0; i < NV; i++) send(tbl[i]);
    wait_results(NV);
    for (int i = 0; i < NV && i < got.size(); i++) begin
      chk($sformatf("vec%0d_msg", i), got[i].msg, tbl[i].msg);
`ifdef FP_PACK_FLAGS_EN
      chk($sformatf("vec%0d_flags", i), {29'd0, got[i].flg}, {29'd0, tbl[i].flg});
`endif
    end
    repeat (3) @(negedge clk);
    got.delete();

    // Backpressure: 4 inputs, consumer stalls 3 cycles.
    fork
      begin
        for (int i = 0; i < 4; i++) send(tbl[i]);
      end
      begin
        repeat (3) @(negedge clk);
        out_rdy = 1'b0;
        #1;
        chk("stall_out_val", {31'd0, out_val}, 32'd1);
        chk("stall_in_rdy", {31'd0, in_rdy}, 32'd0);
        repeat (3) @(negedge clk);
        out_rdy = 1'b1;
      end
    join
    wait_results(4);
    repeat (5) @(negedge clk);
    chk("bp_no_dup", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("bp%0d_msg", i), got[i].msg, tbl[i].msg);
    got.delete();

    // Reset with two results in flight.
    out_rdy = 1'b0;
    send(tbl[1]);
    send(tbl[2]);
    @(negedge clk); #1;
    chk("pre_rst_out_val", {31'd0, out_val}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_val", {31'd0, out_val}, 32'd0);
    chk("rst_async_out_msg", out_msg, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_rdy = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    chk("no_stale_results", got.size(), 0);
    chk("no_stale_out_val", {31'd0, out_val}, 32'd0);

    // Pipe still works after reset.
    send(tbl[3]);
    wait_results(1);
    if (got.size() > 0) chk("post_rst_msg", got[0].msg, tbl[3].msg);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
